// File: rtl/mat_mult_pkg.sv
// mat_mult_pkg: shared CSR map, status bits, FSM states and helpers for the
// matrix-multiply Avalon-MM front-end.
package mat_mult_pkg;

    localparam int CSR_CTRL = 0;
    localparam int CSR_STAT = 1;
    localparam int CSR_CYC  = 2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERR_TO   = 2;
    localparam int STAT_ERR_ADDR = 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STORE} state_t;

    function automatic int mat_words(input int n);
        return 2 * n * n;
    endfunction

    function automatic logic [63:0] avmm_be_merge(input logic [63:0] old_w,
                                                  input logic [63:0] new_w,
                                                  input logic [7:0]  be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++)
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/mat_mult_complex.sv
// mat_mult_complex: complex N x N matrix multiply (64-bit wrap-around parts),
// one result element per cycle while start&valid; done once all are written.
module mat_mult_complex #(
    parameter int N    = 4,
    parameter bit STUB = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    valid,
    input  logic [2*N*N-1:0][63:0]  a,
    input  logic [2*N*N-1:0][63:0]  b,
    output logic [2*N*N-1:0][63:0]  c,
    output logic                    done
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN + 1);
    localparam int CW = $clog2(2 * NN);
    localparam logic [IW-1:0] LAST = IW'(NN);

    logic [IW-1:0]          idx_q, idx_d;
    logic [2*NN-1:0][63:0]  c_q, c_d;
    logic [63:0]            re, im;
    logic                   go;
    int                     e, row, col;

    assign go   = start & valid;
    assign c    = c_q;
    assign done = go & (idx_q == LAST) & ~STUB;

    always_comb begin
        e   = (int'(idx_q) < NN) ? int'(idx_q) : 0;
        row = e / N;
        col = e % N;
        re  = '0;
        im  = '0;
        for (int k = 0; k < N; k++) begin
            re = re + a[CW'(2*(row*N+k))] * b[CW'(2*(k*N+col))]
                    - a[CW'(2*(row*N+k)+1)] * b[CW'(2*(k*N+col)+1)];
            im = im + a[CW'(2*(row*N+k))] * b[CW'(2*(k*N+col)+1)]
                    + a[CW'(2*(row*N+k)+1)] * b[CW'(2*(k*N+col))];
        end
        idx_d = go ? ((idx_q == LAST) ? idx_q : idx_q + 1'b1) : '0;
        c_d   = c_q;
        if (go && idx_q != LAST) begin
            c_d[CW'(2*e)]   = re;
            c_d[CW'(2*e+1)] = im;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

    always_ff @(posedge clk) begin
        c_q <= c_d;
    end

endmodule

// File: rtl/avmm_mat_mult_ctrl.sv
// avmm_mat_mult_ctrl: Avalon-MM slave that banks A/B, runs the complex matmul
// core from a CSR doorbell, captures C and reports status/cycles/irq.
module avmm_mat_mult_ctrl
    import mat_mult_pkg::*;
#(
    parameter int MAT_N     = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 23,
    parameter int TIMEOUT   = 4096,
    parameter bit STUB_CORE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  irq
);

    localparam int WORDS = mat_words(MAT_N);
    localparam int WI    = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] B_BASE   = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] C_BASE   = ADDR_W'(2 * WORDS);
    localparam logic [ADDR_W-1:0] CSR_BASE = ADDR_W'(3 * WORDS);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3 * WORDS + CSR_CTRL);
    localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(3 * WORDS + CSR_STAT);
    localparam logic [ADDR_W-1:0] A_CYC    = ADDR_W'(3 * WORDS + CSR_CYC);

    typedef logic [WORDS-1:0][DATA_W-1:0] bank_t;

    state_t          state_q, state_d;
    bank_t           a_q, a_d, b_q, b_d, c_q, c_d, a_vec_q, a_vec_d, b_vec_q, b_vec_d, core_c;
    logic            done_q, done_d, errt_q, errt_d, erra_q, erra_d, irq_en_q, irq_en_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_val, stat_rd, ctrl_rd;
    logic            rvalid_q, rvalid_d;
    logic            in_a, in_b, in_c, in_mem, csr_hit, busy, wr_acc, rd_acc;
    logic            start_req, timeout_hit, core_done, core_run, load_en, store_en, abort;
    logic [WI-1:0]   wi;

    assign in_a    = address < B_BASE;
    assign in_b    = (address >= B_BASE) && (address < C_BASE);
    assign in_c    = (address >= C_BASE) && (address < CSR_BASE);
    assign in_mem  = in_a | in_b | in_c;
    assign csr_hit = (address == A_CTRL) || (address == A_STAT) || (address == A_CYC);
    assign wi      = in_a ? WI'(address) : in_b ? WI'(address - B_BASE) : WI'(address - C_BASE);

    assign busy        = state_q != S_IDLE;
    assign waitrequest = ~reset & busy & (read | write) & in_mem;
    assign wr_acc      = write & ~waitrequest;
    assign rd_acc      = read & ~write & ~waitrequest;
    assign start_req   = wr_acc && (address == A_CTRL) && byteenable[0]
                         && writedata[CTRL_START] && (state_q == S_IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cyc_q == 32'(TIMEOUT));

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;
    assign irq           = ~reset & done_q & irq_en_q;

    mat_mult_complex #(.N(MAT_N), .STUB(STUB_CORE)) u_core (
        .clk   (clk),
        .reset (reset),
        .start (core_run),
        .valid (core_run),
        .a     (a_vec_q),
        .b     (b_vec_q),
        .c     (core_c),
        .done  (core_done)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = start_req ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = core_done ? S_STORE : timeout_hit ? S_IDLE : S_RUN;
            S_STORE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_en  = state_q == S_LOAD;
        core_run = state_q == S_RUN;
        store_en = state_q == S_STORE;
        abort    = core_run & ~core_done & timeout_hit;
    end

    always_comb begin
        stat_rd                = '0;
        stat_rd[STAT_BUSY]     = busy;
        stat_rd[STAT_DONE]     = done_q;
        stat_rd[STAT_ERR_TO]   = errt_q;
        stat_rd[STAT_ERR_ADDR] = erra_q;
        ctrl_rd                = '0;
        ctrl_rd[CTRL_IRQ_EN]   = irq_en_q;
        rd_val = in_a ? a_q[wi] : in_b ? b_q[wi] : in_c ? c_q[wi] :
                 (address == A_CTRL) ? ctrl_rd : (address == A_STAT) ? stat_rd :
                 (address == A_CYC) ? DATA_W'(cyc_q) : '0;
        rdata_d  = rd_acc ? rd_val : rdata_q;
        rvalid_d = rd_acc;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = store_en ? core_c : c_q;
        a_vec_d  = load_en ? a_q : a_vec_q;
        b_vec_d  = load_en ? b_q : b_vec_q;
        done_d   = done_q | store_en;
        errt_d   = errt_q | abort;
        erra_d   = erra_q;
        irq_en_d = irq_en_q;
        cyc_d    = (core_run && !abort && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        if (wr_acc) begin
            if (in_a)
                a_d[wi] = avmm_be_merge(a_q[wi], writedata, byteenable);
            else if (in_b)
                b_d[wi] = avmm_be_merge(b_q[wi], writedata, byteenable);
            else if (address == A_CTRL && byteenable[0]) begin
                irq_en_d = writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_CLEAR]) begin
                    done_d = 1'b0;
                    errt_d = 1'b0;
                    erra_d = 1'b0;
                end
            end
            else if (!csr_hit || in_c)
                erra_d = 1'b1;
        end
        if (rd_acc && !in_mem && !csr_hit)
            erra_d = 1'b1;
        // A new operation starts from a clean result/timeout/cycle record.
        if (start_req) begin
            done_d = 1'b0;
            errt_d = 1'b0;
            cyc_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            errt_q   <= 1'b0;
            erra_q   <= 1'b0;
            irq_en_q <= 1'b0;
            cyc_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            done_q   <= done_d;
            errt_q   <= errt_d;
            erra_q   <= erra_d;
            irq_en_q <= irq_en_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        c_q     <= c_d;
        a_vec_q <= a_vec_d;
        b_vec_q <= b_vec_d;
    end

endmodule
